// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side end of the 128-bit cache-to-memory request/response channel.
//   One request is served at a time from a wide storage array with a
//   programmable fixed access latency. Writes commit when the request is
//   accepted and return no response. Reads return one beat, or a
//   critical-beat-first wrapped line when bursts are enabled.
//
//   Optional feature macro: MEM_RSP_BURST_EN (multi-beat wrapped read bursts).
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request valid
//   req_ready  out  responder can accept a request (registered)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   quadword address [AW]
//   req_wdata  in   write data [DW]
//   rsp_valid  out  read data beat valid
//   rsp_ready  in   consumer accepts the beat
//   rsp_data   out  read data [DW]
//   rsp_last   out  final beat of a read response
module mem_responder #(
    parameter int AW      = 12,
    parameter int DW      = 128,
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 4,
    parameter int BEATS   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_last
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
    localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

    generate
        if (LATENCY < 1) begin : g_bad_latency
            $error("mem_responder: LATENCY must be >= 1");
        end
        if (DEPTH > (2 ** AW)) begin : g_bad_depth
            $error("mem_responder: DEPTH must not exceed 2**AW");
        end
        if ((BEATS < 1) || ((BEATS & (BEATS - 1)) != 0)) begin : g_bad_beats
            $error("mem_responder: BEATS must be a power of two");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [DW-1:0] mem [0:DEPTH-1];

    state_t        state;
    logic [AW-1:0] addr_q;
    logic          is_write;
    logic [CW-1:0] cnt;
    logic          accept;

`ifdef MEM_RSP_BURST_EN
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [AW-1:0] LINE_MASK = AW'(BEATS - 1);
    localparam logic FIRST_LAST = (BEATS == 1);

    logic [BW-1:0] beat;
    logic [BW-1:0] next_beat;
    logic [AW-1:0] next_addr;

    // Next beat wraps inside the line: upper bits fixed, offset advances mod BEATS.
    assign next_beat = beat + 1'b1;
    assign next_addr = (addr_q & ~LINE_MASK) | ((addr_q + AW'(next_beat)) & LINE_MASK);
`else
    localparam logic FIRST_LAST = 1'b1;
`endif

    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_LIM);
    endfunction

    // Out-of-range reads return zero rather than aliasing into the array.
    function automatic logic [DW-1:0] read_word(input logic [AW-1:0] a);
        if (in_range(a)) begin
            return mem[a[IW-1:0]];
        end
        return '0;
    endfunction

    assign accept = (state == IDLE) && req_ready && req_valid;

    // Writes commit at acceptance, so a following read always sees them.
    // The array has no reset; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (accept && req_we && in_range(req_addr)) begin
            mem[req_addr[IW-1:0]] <= req_wdata;
        end
    end

    // The latency counter is loaded with LATENCY-1 at acceptance and WAIT
    // exits on the edge where it reads 1, so the first beat (or the renewed
    // req_ready after a write) appears exactly LATENCY cycles after the
    // acceptance cycle. LATENCY=1 skips WAIT entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_data  <= '0;
            cnt       <= '0;
            addr_q    <= '0;
            is_write  <= 1'b0;
`ifdef MEM_RSP_BURST_EN
            beat      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        is_write <= req_we;
                        cnt      <= CW'(LATENCY - 1);
                        if (req_we) begin
                            if (LATENCY > 1) begin
                                req_ready <= 1'b0;
                                state     <= WAIT;
                            end
                        end else begin
                            req_ready <= 1'b0;
                            addr_q    <= req_addr;
                            if (LATENCY == 1) begin
                                rsp_data  <= read_word(req_addr);
                                rsp_valid <= 1'b1;
                                rsp_last  <= FIRST_LAST;
                                state     <= RESP;
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (cnt == CW'(1)) begin
                        cnt <= '0;
                        if (is_write) begin
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            rsp_data  <= read_word(addr_q);
                            rsp_valid <= 1'b1;
                            rsp_last  <= FIRST_LAST;
                            state     <= RESP;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
`ifdef MEM_RSP_BURST_EN
                        if (beat == BW'(BEATS - 1)) begin
                            beat      <= '0;
                            rsp_valid <= 1'b0;
                            rsp_last  <= 1'b0;
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            beat     <= next_beat;
                            rsp_data <= read_word(next_addr);
                            rsp_last <= (next_beat == BW'(BEATS - 1));
                        end
`else
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
